io_responder: RTL and testbench

//  Memory-mapped I/O responder: the slave end of the CPU data/address/control bus for

---
 rtl/io_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_io_responder.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// -----------------------------------------------------------------------------
// io_responder
//
// Slave end of the CPU bus for the I/O window. Holds three registers:
//   DIR  (BASE_ADDR)     : last word captured from the input peripheral
//   DOR  (BASE_ADDR + 4) : write-only port into a small FIFO that drains to
//                          the output peripheral over valid/ready
//   SR   (BASE_ADDR + 8) : status flags and FIFO occupancy
// The bus control code is decoded locally:
//   00 idle, 01 read, 10 write, 11 ignored.
// Every access completes in the cycle it is presented.
//
// SR layout:
//   [0] in_full     DIR holds a word the CPU has not read yet
//   [1] fifo_full   DOR FIFO holds FIFO_DEPTH words
//   [2] fifo_empty  DOR FIFO holds no words
//   [3] in_overrun  sticky, input word lost while DIR was full
//   [4] wr_drop     sticky, DOR write lost while FIFO was full
//   [7:5]           zero
//   [8+CW-1:8]      FIFO word count, CW = clog2(FIFO_DEPTH)+1
//   remaining bits  zero
// Reading SR clears both sticky flags on the next edge, unless the same flag
// is set again in that cycle.
//
// Ports:
//   clk_i        system clock, all state updates on the rising edge
//   rst_i        synchronous reset, active-low
//   a_bus_i      bus address
//   c_bus_i      bus control code
//   wr_data_i    CPU write data
//   rd_data_o    read data: DIR or SR selected by address, else 0 (comb.)
//   hit_o        address matches DIR, DOR or SR (comb.)
//   in_valid_i   input peripheral strobe, one word per high cycle
//   in_data_i    input peripheral data
//   in_ready_o   DIR can take a word without overrun
//   out_valid_o  DOR FIFO non-empty
//   out_data_o   DOR FIFO head (0 while empty)
//   out_ready_i  output peripheral accepts the head this cycle
// -----------------------------------------------------------------------------
module io_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0404,
  parameter int          FIFO_DEPTH = 4,
  parameter int          DW         = 32
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [31:0]   a_bus_i,
  input  logic [1:0]    c_bus_i,
  input  logic [DW-1:0] wr_data_i,
  output logic [DW-1:0] rd_data_o,
  output logic          hit_o,
  input  logic          in_valid_i,
  input  logic [DW-1:0] in_data_i,
  output logic          in_ready_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  input  logic          out_ready_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0]   DIR_ADDR = BASE_ADDR;
  localparam logic [31:0]   DOR_ADDR = BASE_ADDR + 32'd4;
  localparam logic [31:0]   SR_ADDR  = BASE_ADDR + 32'd8;
  localparam logic [1:0]    C_READ   = 2'b01;
  localparam logic [1:0]    C_WRITE  = 2'b10;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [DW-1:0] dir_q,      dir_d;
  logic          in_full_q,  in_full_d;
  logic          overrun_q,  overrun_d;
  logic          wr_drop_q,  wr_drop_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic sel_dir, sel_dor, sel_sr;
  logic dir_rd, sr_rd, dor_wr;

  always_comb begin
    sel_dir = (a_bus_i == DIR_ADDR);
    sel_dor = (a_bus_i == DOR_ADDR);
    sel_sr  = (a_bus_i == SR_ADDR);
    dir_rd  = sel_dir && (c_bus_i == C_READ);
    sr_rd   = sel_sr  && (c_bus_i == C_READ);
    dor_wr  = sel_dor && (c_bus_i == C_WRITE);
  end

  assign hit_o = sel_dir | sel_dor | sel_sr;

  // ---------------------------------------------------------------------------
  // Status word
  // ---------------------------------------------------------------------------
  logic          fifo_full, fifo_empty;
  logic [DW-1:0] sr_word;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);

  always_comb begin
    sr_word          = '0;
    sr_word[0]       = in_full_q;
    sr_word[1]       = fifo_full;
    sr_word[2]       = fifo_empty;
    sr_word[3]       = overrun_q;
    sr_word[4]       = wr_drop_q;
    sr_word[8 +: CW] = count_q;
  end

  // Read mux follows the address only; DOR and unmapped addresses read 0.
  always_comb begin
    rd_data_o = '0;
    if (sel_dir) begin
      rd_data_o = dir_q;
    end else if (sel_sr) begin
      rd_data_o = sr_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Input path
  // ---------------------------------------------------------------------------
  // A word is accepted when DIR is free, or when the CPU is emptying DIR in
  // this very cycle: the old value goes out on the bus, the new one is
  // latched and DIR stays full without counting as an overrun.
  logic in_accept, overrun_set;

  assign in_accept   = in_valid_i && (!in_full_q || dir_rd);
  assign overrun_set = in_valid_i && in_full_q && !dir_rd;
  assign in_ready_o  = ~in_full_q;

  always_comb begin
    dir_d     = dir_q;
    in_full_d = in_full_q;
    if (in_accept) begin
      dir_d     = in_data_i;
      in_full_d = 1'b1;
    end else if (dir_rd) begin
      in_full_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  // A pop in the same cycle frees a slot, so a write into a full FIFO that
  // is also draining is still accepted.
  logic fifo_pop, fifo_push, drop_set;

  assign out_valid_o = ~fifo_empty;
  assign fifo_pop    = out_valid_o && out_ready_i;
  assign fifo_push   = dor_wr && (!fifo_full || fifo_pop);
  assign drop_set    = dor_wr && fifo_full && !fifo_pop;
  assign out_data_o  = out_valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (fifo_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    unique case ({fifo_push, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sticky flags: a set in the cycle of the clearing read wins.
  // ---------------------------------------------------------------------------
  always_comb begin
    overrun_d = overrun_set || (overrun_q && !sr_rd);
    wr_drop_d = drop_set    || (wr_drop_q && !sr_rd);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      dir_q     <= '0;
      in_full_q <= 1'b0;
      overrun_q <= 1'b0;
      wr_drop_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      dir_q     <= dir_d;
      in_full_q <= in_full_d;
      overrun_q <= overrun_d;
      wr_drop_q <= wr_drop_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid,
  // and the output is forced to 0 while empty.
  always_ff @(posedge clk_i) begin
    if (rst_i && fifo_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
module tb_io_responder;

  localparam logic [31:0] DIR_A = 32'h0000_0404;
  localparam logic [31:0] DOR_A = 32'h0000_0408;
  localparam logic [31:0] SR_A  = 32'h0000_040C;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        rst;
  logic [31:0] a_bus;
  logic [1:0]  c_bus;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        hit;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  int n_vec = 0;
  int n_err = 0;

  io_responder #(
    .BASE_ADDR (32'h0000_0404),
    .FIFO_DEPTH(DEPTH),
    .DW        (32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .a_bus_i    (a_bus),
    .c_bus_i    (c_bus),
    .wr_data_i  (wr_data),
    .rd_data_o  (rd_data),
    .hit_o      (hit),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [31:0] a;
    logic [1:0]  c;
    logic [31:0] wd;
    bit          iv;
    logic [31:0] id;
    bit          ordy;
    bit          chk;
    bit          chk_rd;
    logic [31:0] erd;
    bit          ehit;
    bit          eir;
    bit          eov;
    logic [31:0] eod;
  } vec_t;

  vec_t tbl[$];

  // Reference model: plain queue plus flag bits.
  logic [31:0] m_dir;
  bit          m_full, m_ovr, m_drop;
  logic [31:0] m_q[$];

  function automatic logic [31:0] m_sr();
    int n = m_q.size();
    return {21'b0, 3'(n), 3'b0, m_drop, m_ovr, (n == 0), (n == DEPTH), m_full};
  endfunction

  function automatic void model_update(input vec_t v);
    bit dir_rd, sr_rd, dor_wr, set_ovr, set_drop, pop;
    int n_before;
    if (!v.rst) begin
      m_dir = '0; m_full = 0; m_ovr = 0; m_drop = 0;
      m_q.delete();
      return;
    end
    dir_rd   = (v.c == 2'b01) && (v.a == DIR_A);
    sr_rd    = (v.c == 2'b01) && (v.a == SR_A);
    dor_wr   = (v.c == 2'b10) && (v.a == DOR_A);
    set_ovr  = v.iv && m_full && !dir_rd;
    if (v.iv && (!m_full || dir_rd)) begin
      m_dir  = v.id;
      m_full = 1;
    end else if (dir_rd) begin
      m_full = 0;
    end
    n_before = m_q.size();
    pop      = (n_before > 0) && v.ordy;
    set_drop = 0;
    if (pop) void'(m_q.pop_front());
    if (dor_wr) begin
      if (n_before < DEPTH || pop) m_q.push_back(v.wd);
      else set_drop = 1;
    end
    m_ovr  = set_ovr  || (m_ovr  && !sr_rd);
    m_drop = set_drop || (m_drop && !sr_rd);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst       = v.rst;
    a_bus     = v.a;
    c_bus     = v.c;
    wr_data   = v.wd;
    in_valid  = v.iv;
    in_data   = v.id;
    out_ready = v.ordy;
  endtask

  // One bus cycle: drive, compare at the falling edge, advance model and DUT.
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    logic [31:0] erd;
    drive(v);
    @(negedge clk);
    if (use_tbl) begin
      if (v.chk) begin
        if (v.chk_rd) check({tag, " rd_data"}, rd_data, v.erd);
        check({tag, " hit"},       {31'b0, hit},       {31'b0, v.ehit});
        check({tag, " in_ready"},  {31'b0, in_ready},  {31'b0, v.eir});
        check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, v.eov});
        if (v.eov) check({tag, " out_data"}, out_data, v.eod);
      end
    end else begin
      check({tag, " hit"}, {31'b0, hit},
            {31'b0, (v.a == DIR_A) || (v.a == DOR_A) || (v.a == SR_A)});
      check({tag, " in_ready"},  {31'b0, in_ready},  {31'b0, !m_full});
      check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, m_q.size() != 0});
      if (m_q.size() != 0) check({tag, " out_data"}, out_data, m_q[0]);
      if (v.c == 2'b01) begin
        erd = (v.a == DIR_A) ? m_dir : (v.a == SR_A) ? m_sr() : 32'h0;
        check({tag, " rd_data"}, rd_data, erd);
      end
    end
    model_update(v);
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit r, logic [31:0] a, logic [1:0] c, logic [31:0] wd,
                              bit iv, logic [31:0] id, bit ordy, bit chk, bit chk_rd,
                              logic [31:0] erd, bit ehit, bit eir, bit eov,
                              logic [31:0] eod);
    vec_t v;
    v.rst = r; v.a = a; v.c = c; v.wd = wd; v.iv = iv; v.id = id; v.ordy = ordy;
    v.chk = chk; v.chk_rd = chk_rd; v.erd = erd; v.ehit = ehit; v.eir = eir;
    v.eov = eov; v.eod = eod;
    return v;
  endfunction

  // Shorthands: SR/DIR read, idle cycle, plain DOR write.
  function automatic vec_t rdv(logic [31:0] a, bit iv, logic [31:0] id, bit ordy,
                               logic [31:0] erd, bit eir, bit eov, logic [31:0] eod);
    return mk(1, a, 2'b01, 0, iv, id, ordy, 1, 1, erd, 1, eir, eov, eod);
  endfunction

  function automatic vec_t idl(bit iv, logic [31:0] id, bit ordy, bit eir, bit eov,
                               logic [31:0] eod);
    return mk(1, 0, 2'b00, 0, iv, id, ordy, 1, 0, 0, 0, eir, eov, eod);
  endfunction

  function automatic vec_t wrv(logic [31:0] wd, bit ordy, bit eov, logic [31:0] eod);
    return mk(1, DOR_A, 2'b10, wd, 0, 0, ordy, 1, 0, 0, 1, 1, eov, eod);
  endfunction

  initial begin
    vec_t v;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;

    // Reset held two cycles under bus traffic, then clean status.
    tbl.push_back(mk(0, DOR_A, 2'b10, 32'h55, 1, 32'h77, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, DOR_A, 2'b10, 32'h55, 1, 32'h77, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(rdv(SR_A, 0, 0, 0, 32'h4, 1, 0, 0));
    // Input capture and DIR read.
    tbl.push_back(idl(1, 32'hDEAD_BEEF, 0, 1, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'h5, 0, 0, 0));
    tbl.push_back(rdv(DIR_A, 0, 0, 0, 32'hDEAD_BEEF, 0, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'h4, 1, 0, 0));
    // Overrun and clear-on-read.
    tbl.push_back(idl(1, 32'h11, 0, 1, 0, 0));
    tbl.push_back(idl(1, 32'h22, 0, 0, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'hD, 0, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'h5, 0, 0, 0));
    tbl.push_back(rdv(DIR_A, 0, 0, 0, 32'h11, 0, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'h4, 1, 0, 0));
    // FIFO fill with a dropped fifth word.
    tbl.push_back(wrv(32'h1, 0, 0, 0));
    tbl.push_back(wrv(32'h2, 0, 1, 32'h1));
    tbl.push_back(wrv(32'h3, 0, 1, 32'h1));
    tbl.push_back(wrv(32'h4, 0, 1, 32'h1));
    tbl.push_back(wrv(32'h5, 0, 1, 32'h1));
    tbl.push_back(rdv(SR_A, 0, 0, 0, 32'h412, 1, 1, 32'h1));
    tbl.push_back(rdv(SR_A, 0, 0, 0, 32'h402, 1, 1, 32'h1));
    // Full FIFO: push and pop together, 0x99 drains last.
    tbl.push_back(wrv(32'h99, 1, 1, 32'h1));
    tbl.push_back(rdv(SR_A, 0, 0, 0, 32'h402, 1, 1, 32'h2));
    tbl.push_back(idl(0, 0, 1, 1, 1, 32'h2));
    tbl.push_back(idl(0, 0, 1, 1, 1, 32'h3));
    tbl.push_back(idl(0, 0, 1, 1, 1, 32'h4));
    tbl.push_back(idl(0, 0, 1, 1, 1, 32'h99));
    tbl.push_back(rdv(SR_A, 0, 0, 1, 32'h4, 1, 0, 0));
    // Ignored accesses and unmapped address.
    tbl.push_back(mk(1, DIR_A, 2'b10, 32'hABC, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(rdv(DOR_A, 0, 0, 0, 32'h0, 1, 0, 0));
    tbl.push_back(rdv(DIR_A, 0, 0, 0, 32'h11, 1, 0, 0));
    tbl.push_back(mk(1, DOR_A, 2'b11, 32'hBAD, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    tbl.push_back(rdv(SR_A, 0, 0, 0, 32'h4, 1, 0, 0));
    tbl.push_back(mk(1, 32'h400, 2'b01, 0, 0, 0, 0, 1, 1, 32'h0, 0, 1, 0, 0));
    // DIR read racing a new input word while full.
    tbl.push_back(idl(1, 32'hA1, 0, 1, 0, 0));
    tbl.push_back(rdv(DIR_A, 1, 32'hA2, 0, 32'hA1, 0, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'h5, 0, 0, 0));
    tbl.push_back(rdv(DIR_A, 0, 0, 0, 32'hA2, 0, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'h4, 1, 0, 0));
    // Overrun set in the same cycle as the clearing SR read.
    tbl.push_back(idl(1, 32'h1, 0, 1, 0, 0));
    tbl.push_back(rdv(SR_A,  1, 32'h2, 0, 32'h5, 0, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'hD, 0, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'h5, 0, 0, 0));
    tbl.push_back(rdv(DIR_A, 0, 0, 0, 32'h1, 0, 0, 0));
    tbl.push_back(rdv(SR_A,  0, 0, 0, 32'h4, 1, 0, 0));

    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Randomised traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      case ($urandom_range(7))
        0, 1:    v.a = DIR_A;
        2, 3:    v.a = DOR_A;
        4, 5:    v.a = SR_A;
        6:       v.a = 32'h400;
        default: v.a = $urandom;
      endcase
      v.rst  = ($urandom_range(63) != 0);
      v.c    = 2'($urandom_range(3));
      v.wd   = $urandom;
      v.iv   = ($urandom_range(1) == 1);
      v.id   = $urandom;
      v.ordy = ($urandom_range(9) < 6);
      step(v, 1'b0, "rand");
    end

    // Reset in the middle of a drain discards the queued words.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "r6 rst");
    step(mk(1, DOR_A, 2'b10, 32'hA, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "r6 wr");
    step(mk(1, DOR_A, 2'b10, 32'hB, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "r6 wr");
    step(mk(1, DOR_A, 2'b10, 32'hC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "r6 wr");
    check("r6 queued out_valid", {31'b0, out_valid}, 32'h1);
    check("r6 queued head", out_data, 32'hA);
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, "r6 mid");
    check("r6 out_valid after reset", {31'b0, out_valid}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(mk(1, SR_A, 2'b01, 0, 0, 0, 1, 1, 1, 32'h4, 1, 1, 0, 0), 1'b1, "r6 drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
